// File: rtl/fir_filter_precision_converter.sv
// Precision converter between FIR accumulators and narrower datapaths.
// Drops guard MSBs and fraction LSBs with selectable rounding, optional
// saturation, a two-stage valid/ready pipeline and a sticky overflow counter.
module fir_filter_precision_converter #(
  parameter int INPUT_WIDTH   = 64,
  parameter int OUTPUT_WIDTH  = 32,
  parameter int OFFSET_BITS   = 1,
  parameter int CHANNELS      = 1,
  parameter int OVF_CNT_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CHANNELS*INPUT_WIDTH-1:0]  in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [1:0]                       round_mode,
  input  logic                             sat_en,
  output logic [CHANNELS*OUTPUT_WIDTH-1:0] out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CHANNELS-1:0]              out_ovf,
  output logic [OVF_CNT_WIDTH-1:0]         ovf_count,
  input  logic                             ovf_clr
);

  // number of discarded fraction bits
  localparam int D  = INPUT_WIDTH - OFFSET_BITS - OUTPUT_WIDTH;
  // sign-extended sum width, so adding the rounding constant never overflows
  localparam int SW = INPUT_WIDTH + 1;
  // only s[SW-1:D] matters downstream: kept field plus the overflow-check bits
  localparam int HW = SW - D;
  localparam logic [SW-1:0] HALF = SW'(1) << (D - 1);

  if (D < 1) begin : g_bad_width
    $error("fir_filter_precision_converter: INPUT_WIDTH-OFFSET_BITS-OUTPUT_WIDTH must be >= 1");
  end

  // Rounded sum of one lane, returning only the bits at and above position D.
  // Mode 3 falls through to truncation.
  function automatic logic [HW-1:0] round_hi(input logic [INPUT_WIDTH-1:0] x,
                                             input logic [1:0]             mode);
    logic [SW-1:0] r;
    case (mode)
      2'd1:    r = HALF;
      2'd2:    r = HALF - SW'(1) + SW'(x[D]);
      default: r = '0;
    endcase
    return HW'(({x[INPUT_WIDTH-1], x} + r) >> D);
  endfunction

  logic [HW-1:0]                   s1_hi [CHANNELS];
  logic                            s1_sat;
  logic                            s1_valid;
  logic                            s2_valid;
  logic                            en1;
  logic                            en2;
  logic [CHANNELS*OUTPUT_WIDTH-1:0] s2_data_d;
  logic [CHANNELS-1:0]             s2_ovf_d;

  assign en2       = !s2_valid || out_ready;
  assign en1       = !s1_valid || en2;
  assign in_ready  = en1;
  assign out_valid = s2_valid;

  // Stage 1 valid bit
  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else if (en1) s1_valid <= in_valid;
  end

  // Stage 1 data: rounded sums and the sat_en captured with the beat
  always_ff @(posedge clk) begin
    if (en1 && in_valid) begin
      for (int k = 0; k < CHANNELS; k++)
        s1_hi[k] <= round_hi(in_data[k*INPUT_WIDTH +: INPUT_WIDTH], round_mode);
      s1_sat <= sat_en;
    end
  end

  // Overflow detection and saturate/wrap selection for each lane
  always_comb begin
    s2_data_d = '0;
    s2_ovf_d  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      s2_ovf_d[k] = !((&s1_hi[k][HW-1:OUTPUT_WIDTH-1]) || !(|s1_hi[k][HW-1:OUTPUT_WIDTH-1]));
      if (s2_ovf_d[k] && s1_sat)
        s2_data_d[k*OUTPUT_WIDTH +: OUTPUT_WIDTH] = s1_hi[k][HW-1] ?
          {1'b1, {(OUTPUT_WIDTH-1){1'b0}}} : {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
      else
        s2_data_d[k*OUTPUT_WIDTH +: OUTPUT_WIDTH] = s1_hi[k][OUTPUT_WIDTH-1:0];
    end
  end

  // Stage 2 output register; holds while the downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_ovf  <= '0;
    end else if (en2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= s2_data_d;
        out_ovf  <= s2_ovf_d;
      end
    end
  end

  // Saturating count of delivered beats with any lane overflowed; clear wins
  always_ff @(posedge clk) begin
    if (rst || ovf_clr)
      ovf_count <= '0;
    else if (out_valid && out_ready && (|out_ovf) && !(&ovf_count))
      ovf_count <= ovf_count + OVF_CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_fir_filter_precision_converter.sv
// Bench for fir_filter_precision_converter (16-bit in, 8-bit out, one guard bit).
// Integer reference model plus a scoreboard queue; directed and random stimulus.
module tb_fir_filter_precision_converter;

  localparam int IW = 16;
  localparam int OW = 8;
  localparam int OB = 1;
  localparam int CH = 1;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH*IW-1:0]  in_data;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        round_mode;
  logic              sat_en;
  logic [CH*OW-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic [CH-1:0]     out_ovf;
  logic [CW-1:0]     ovf_count;
  logic              ovf_clr;

  fir_filter_precision_converter #(
    .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .OFFSET_BITS(OB),
    .CHANNELS(CH), .OVF_CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .round_mode(round_mode), .sat_en(sat_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ovf(out_ovf), .ovf_count(ovf_count), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: floor((x + R) / 2^7), then range check against signed 8 bits
  function automatic logic [8:0] ref_conv(input logic [15:0] x, input logic [1:0] mode,
                                          input logic sat);
    int xs;
    int r;
    int q;
    logic ovf;
    xs = int'(signed'(x));
    if (mode == 2'd1)      r = 64;
    else if (mode == 2'd2) r = 63 + int'(x[7]);
    else                   r = 0;
    q = (xs + r) >>> 7;
    ovf = (q > 127) || (q < -128);
    if (ovf && sat) q = (q > 0) ? 127 : -128;
    return {ovf, 8'(q)};
  endfunction

  typedef struct {
    logic [7:0] d;
    logic       ovf;
    int         acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [8:0]  r_tmp;
  int          cyc = 0;
  int          rdy_run = 0;
  int          cnt_m = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_d = '0;
  logic        prev_o = 1'b0;
  logic        acc_last = 1'b0;
  logic        saw_nrdy = 1'b0;

  // Mid-cycle monitor: checks outputs, then advances the model for the next edge
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
      cnt_m      = 0;
      prev_stall = 1'b0;
      rdy_run    = 0;
      acc_last   = 1'b0;
    end else begin
      rdy_run = out_ready ? rdy_run + 1 : 0;
      check("in_ready", in_ready, (sb.size() < 2) || out_ready);
      check("ovf_count", ovf_count, cnt_m);
      if (sb.size() == 0) check("idle_valid", out_valid, 0);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_d);
        check("hold_ovf", out_ovf, prev_o);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("extra_beat", out_valid && out_ready, 0);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.d);
          check("out_ovf", out_ovf, e.ovf);
          if (rdy_run >= cyc - e.acc) check("latency", cyc - e.acc, 2);
        end
        if ((|out_ovf) && cnt_m < 65535) cnt_m++;
      end
      if (ovf_clr) cnt_m = 0;
      if (!in_ready) saw_nrdy = 1'b1;
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_o     = out_ovf;
      acc_last   = in_valid && in_ready;
      if (acc_last) begin
        r_tmp = ref_conv(in_data, round_mode, sat_en);
        sb.push_back('{d: r_tmp[7:0], ovf: r_tmp[8], acc: cyc});
      end
    end
  end

  task automatic drive_beat(input logic [15:0] x, input logic [1:0] m, input logic s);
    logic ok;
    ok = 1'b0;
    in_data = x; round_mode = m; sat_en = s; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (acc_last) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", ok, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; round_mode = 2'd0;
    sat_en = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_ovf_count", ovf_count, 0);
    @(posedge clk); #1;

    // rounding ties and overflow corners
    for (int m = 0; m < 3; m++) drive_beat(16'h0040, 2'(m), 1'b1);
    for (int m = 0; m < 3; m++) drive_beat(16'h00C0, 2'(m), 1'b1);
    drive_beat(16'h0140, 2'd2, 1'b1);
    drive_beat(16'h7FFF, 2'd1, 1'b1);
    drive_beat(16'h7FFF, 2'd1, 1'b0);
    drive_beat(16'h8000, 2'd1, 1'b1);
    drive_beat(16'h1234, 2'd3, 1'b0);
    drain();
    check("ovf_cnt_three", ovf_count, 3);

    // backpressure: out_ready low for cycles 3..6
    saw_nrdy = 1'b0;
    fork
      begin
        for (int k = 1; k <= 6; k++) drive_beat(16'(k * 16'h0080), 2'd0, 1'b0);
      end
      begin
        for (int c = 0; c < 12; c++) begin
          out_ready = !(c >= 3 && c <= 6);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_in_ready_drop", saw_nrdy, 1);

    // randomized traffic, modes, saturation and clears
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (!in_valid || acc_last) begin
        in_valid   = ($urandom_range(3) != 0);
        in_data    = ($urandom_range(2) == 0) ? 16'($urandom_range(16'h7F00, 16'h80FF))
                                              : 16'($urandom);
        round_mode = 2'($urandom_range(3));
        sat_en     = 1'($urandom_range(1));
      end
      out_ready = ($urandom_range(3) != 0);
      ovf_clr   = ($urandom_range(31) == 0);
    end
    in_valid = 1'b0; ovf_clr = 1'b0; out_ready = 1'b1;
    drain();

    // counter saturation, then clear colliding with an overflow handshake
    in_data = 16'h7FFF; round_mode = 2'd1; sat_en = 1'b1; in_valid = 1'b1;
    repeat (65540) @(posedge clk);
    @(negedge clk);
    check("ovf_cnt_sat", ovf_count, 16'hFFFF);
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("ovf_clr_prio", ovf_count, 0);
    @(posedge clk); #1;
    drain();

    // reset with two beats buffered
    out_ready = 1'b0;
    drive_beat(16'h0100, 2'd0, 1'b0);
    drive_beat(16'h0180, 2'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_ovf_count", ovf_count, 0);
    @(posedge clk); #1 out_ready = 1'b1;
    drive_beat(16'h0100, 2'd0, 1'b0);
    drain();
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_filter_precision_converter.md
Name: fir_filter_precision_converter

Overview:
- Pipelined, multi-channel precision converter placed between FIR accumulator outputs and narrower downstream datapaths.
- Takes signed fixed-point samples of INPUT_WIDTH bits and drops OFFSET_BITS guard MSBs and the discarded fraction LSBs.
- Applies a runtime-selectable rounding mode and optional saturation.
- Carries a valid/ready handshake and keeps a sticky overflow counter.

Parameters:
- INPUT_WIDTH, 64: width of each signed input sample.
- OUTPUT_WIDTH, 32: width of each signed output sample.
- OFFSET_BITS, 1: guard bits between the sample MSB and the first kept bit.
- CHANNELS, 1: number of parallel lanes; all lanes share one handshake.
- OVF_CNT_WIDTH, 16: width of the overflow counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_data  in  CHANNELS*INPUT_WIDTH  lane k occupies bits [k*INPUT_WIDTH +: INPUT_WIDTH].
- in_valid  in  1  input beat valid.
- in_ready  out  1  converter can accept a beat.
- round_mode  in  2  0 truncate, 1 round-half-up, 2 convergent (half-to-even), 3 treated as truncate; sampled with the beat.
- sat_en  in  1  1 = clamp on overflow, 0 = wrap; sampled with the beat.
- out_data  out  CHANNELS*OUTPUT_WIDTH  converted lanes, same packing as in_data.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_ovf  out  CHANNELS  per-lane overflow flag for the current output beat.
- ovf_count  out  OVF_CNT_WIDTH  number of accepted output beats with any out_ovf bit set; saturates at all-ones.
- ovf_clr  in  1  synchronous clear of ovf_count.

Behaviour:
- Elaboration check: D = INPUT_WIDTH-OFFSET_BITS-OUTPUT_WIDTH must be >= 1; otherwise $error.
- Per-lane arithmetic: x is the signed input. The kept field is x[INPUT_WIDTH-1-OFFSET_BITS : D].
  - Rounding constant R:
    - truncate: R = 0.
    - half-up: R = 2^(D-1).
    - convergent: R = 2^(D-1)-1+x[D].
  - s = sext(x, INPUT_WIDTH+1) + R, computed without overflow.
  - res = s[D+OUTPUT_WIDTH-1 : D].
  - Overflow when bits s[INPUT_WIDTH : D+OUTPUT_WIDTH-1] are not all equal.
  - On overflow with sat_en=1: output 0 followed by all ones if s is positive, 1 followed by all zeros if negative.
  - On overflow with sat_en=0: output res (wrap).
  - out_ovf reports overflow regardless of sat_en.
- Pipeline: two registered stages.
  - S1 registers the rounded sums s plus the captured sat_en.
  - S2 registers the saturated/wrapped result and overflow flags.
  - Latency is exactly 2 cycles from input handshake to out_valid when out_ready stays high. Throughput is 1 beat/cycle.
- Handshake:
  - en2 = !s2_valid || out_ready.
  - en1 = !s1_valid || en2.
  - in_ready = en1, combinational from out_ready.
  - A beat is accepted when in_valid && in_ready.
  - While out_valid && !out_ready, out_data and out_ovf hold stable.
  - No beat is dropped or duplicated. Up to 2 beats are buffered under backpressure.
- Mode changes apply per beat. Beats already in flight keep the mode captured at their acceptance.
- ovf_count:
  - Increments by 1 on each output handshake where |out_ovf is set.
  - Holds at all-ones.
  - ovf_clr has priority over a simultaneous increment; the result is 0.
- Reset (any cycle, including mid-stream):
  - s1_valid, s2_valid, out_valid are 0; out_data and out_ovf are 0; ovf_count is 0.
  - Buffered beats are discarded.
  - in_ready is 1 in the first cycle after reset deasserts.
- Data registers need no reset beyond the outputs listed above. The valid bits are always reset.

Test Plan:
All cases use INPUT_WIDTH=16, OUTPUT_WIDTH=8, OFFSET_BITS=1, CHANNELS=1, which gives D=7.
- Rounding tie, x=0x0040: truncate -> 0x00; half-up -> 0x01; convergent -> 0x00. out_ovf=0 in all modes. out_valid appears exactly 2 cycles after acceptance.
- Rounding tie, x=0x00C0: truncate -> 0x01; half-up -> 0x02; convergent -> 0x02. Then x=0x0140 in convergent mode -> 0x02.
- Overflow, x=0x7FFF in half-up mode: sat_en=1 -> 0x7F, out_ovf=1; sat_en=0 -> 0x00, out_ovf=1. Then x=0x8000 with sat_en=1 -> 0x80, out_ovf=1, and ovf_count=3 after these three beats are accepted.
- Backpressure: stream 6 beats 0x0080..0x0300 (step 0x0080) with out_ready low for cycles 3-6. Required:
  - in_ready drops once 2 beats are buffered.
  - Output sequence is 0x01..0x06 in order with no loss.
  - out_data is stable while stalled.
- ovf_count: drive 0xFFFF+ overflow beats until the counter saturates at 0xFFFF. Assert ovf_clr on the same cycle as an overflow handshake -> ovf_count=0 next cycle.
- Reset mid-stream: assert rst with 2 beats buffered and out_ready=0. Next cycle out_valid=0 and ovf_count=0. The first beat after reset emerges 2 cycles after its acceptance, with no stale data.
